// File: rtl/wb_scoreboard.sv
// Writeback scoreboard: tracks registers with an outstanding write
// (pending vector) and merges load responses with single-cycle results
// into one registered register-file write port. Loads always win; a
// single-cycle result that collides with a load parks in a one-entry skid.
module wb_scoreboard #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              issue_valid,
  input  logic [4:0]        issue_rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  output logic              stall,
  input  logic              alu_valid,
  input  logic [4:0]        alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              ld_valid,
  input  logic [4:0]        ld_rd,
  input  logic [DATA_W-1:0] ld_data,
  output logic              wb_we,
  output logic [4:0]        wb_rd,
  output logic [DATA_W-1:0] wb_data
);

  typedef struct packed {
    logic [4:0]        rd;
    logic [DATA_W-1:0] data;
  } wb_ent_t;

  typedef enum logic {EMPTY, FULL} skid_st_t;

  skid_st_t    st;
  wb_ent_t     skid;
  logic [31:0] pending;
  logic [31:0] pend_vis;
  logic [31:0] pend_nxt;
  logic        alu_acc;
  logic        issue_fire;
  logic        sel_v;
  wb_ent_t     sel;

  // x0 is never a hazard, even if a stray bit were ever present
  assign pend_vis   = pending & ~32'h1;
  assign stall      = issue_valid & (pend_vis[rs1] | pend_vis[rs2] | pend_vis[issue_rd]);
  assign issue_fire = issue_valid & ~stall & (issue_rd != 5'd0);
  assign alu_ready  = (st == EMPTY);
  assign alu_acc    = alu_valid & alu_ready;

  // Writeback source select: load > skid > direct single-cycle result
  always_comb begin
    sel_v = 1'b0;
    sel   = '{rd: ld_rd, data: ld_data};
    if (ld_valid) begin
      sel_v = 1'b1;
    end else if (st == FULL) begin
      sel_v = 1'b1;
      sel   = skid;
    end else if (alu_acc) begin
      sel_v = 1'b1;
      sel   = '{rd: alu_rd, data: alu_data};
    end
  end

  // Skid buffer: fill on load collision, hold under loads, drain otherwise
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st   <= EMPTY;
      skid <= '0;
    end else begin
      case (st)
        EMPTY: if (ld_valid && alu_acc) begin
          st   <= FULL;
          skid <= '{rd: alu_rd, data: alu_data};
        end
        FULL: if (!ld_valid) st <= EMPTY;
        default: st <= EMPTY;
      endcase
    end
  end

  // Registered writeback port; index/data hold when nothing is selected
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we   <= 1'b0;
      wb_rd   <= '0;
      wb_data <= '0;
    end else begin
      wb_we <= sel_v & (sel.rd != 5'd0);
      if (sel_v) begin
        wb_rd   <= sel.rd;
        wb_data <= sel.data;
      end
    end
  end

  // Pending update: clear with the register-file write, then set (set wins)
  always_comb begin
    pend_nxt = pending;
    if (wb_we) pend_nxt[wb_rd] = 1'b0;
    if (issue_fire) pend_nxt[issue_rd] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Pending vector state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= pend_nxt;
  end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Self-checking bench for wb_scoreboard: directed scenarios plus random
// traffic, checked against a queue-based reference model; writebacks are
// compared by an independent monitor popping an expected-write queue.
module tb_wb_scoreboard;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        issue_valid = 1'b0;
  logic [4:0]  issue_rd = '0, rs1 = '0, rs2 = '0;
  logic        stall;
  logic        alu_valid = 1'b0;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        alu_ready;
  logic        ld_valid = 1'b0;
  logic [4:0]  ld_rd = '0;
  logic [31:0] ld_data = '0;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  int checks = 0;
  int errors = 0;

  // reference model state
  ent_t exp_q[$];
  ent_t skq[$];
  bit   mp[32];
  bit   m_wb_v;
  int   m_wb_rd;

  wb_scoreboard #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .rs1(rs1), .rs2(rs2),
    .stall(stall),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit pend(input int r);
    return (r != 0) && mp[r];
  endfunction

  // One clock cycle of stimulus; model predicts combinational outputs and
  // the write that must appear on the next cycle.
  task automatic cycle(input bit iv, input int ird, input int r1, input int r2,
                       input bit av, input int ard, input logic [31:0] ad,
                       input bit lv, input int lrd, input logic [31:0] ldd);
    bit   exp_stall, acc, sel_v;
    ent_t sel;
    @(posedge clk); #1;
    issue_valid = iv; issue_rd = 5'(ird); rs1 = 5'(r1); rs2 = 5'(r2);
    alu_valid = av; alu_rd = 5'(ard); alu_data = ad;
    ld_valid = lv; ld_rd = 5'(lrd); ld_data = ldd;
    #1;
    exp_stall = iv && (pend(r1) || pend(r2) || pend(ird));
    chk("stall", 64'(stall), 64'(exp_stall));
    chk("alu_ready", 64'(alu_ready), 64'(skq.size() == 0));
    acc   = av && (skq.size() == 0);
    sel_v = 1'b0;
    sel.rd = '0; sel.data = '0;
    if (lv) begin
      sel.rd = 5'(lrd); sel.data = ldd; sel_v = 1'b1;
      if (acc) skq.push_back('{rd: 5'(ard), data: ad});
    end else if (skq.size() != 0) begin
      sel = skq.pop_front(); sel_v = 1'b1;
    end else if (acc) begin
      sel.rd = 5'(ard); sel.data = ad; sel_v = 1'b1;
    end
    if (sel_v && sel.rd != 0) exp_q.push_back(sel);
    if (m_wb_v) mp[m_wb_rd] = 1'b0;
    if (iv && !exp_stall && ird != 0) mp[ird] = 1'b1;
    m_wb_v  = sel_v && (sel.rd != 0);
    m_wb_rd = sel.rd;
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic model_clear();
    exp_q.delete();
    skq.delete();
    foreach (mp[i]) mp[i] = 1'b0;
    m_wb_v = 1'b0;
  endtask

  // Mid-operation reset: state must vanish at once with no write emitted
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    issue_valid = 1'b1; issue_rd = 5'd4; rs1 = 5'd4; rs2 = 5'd5;
    alu_valid = 1'b0; ld_valid = 1'b0;
    model_clear();
    #1;
    chk("rst_alu_ready", 64'(alu_ready), 64'd1);
    chk("rst_wb_we", 64'(wb_we), 64'd0);
    chk("rst_stall", 64'(stall), 64'd0);
    chk("rst_wb_rd", 64'(wb_rd), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    issue_valid = 1'b0;
    rst = 1'b0;
  endtask

  // Monitor: every register-file write must match the next expected entry
  initial begin
    ent_t e;
    forever begin
      @(negedge clk);
      if (!rst && wb_we) begin
        if (exp_q.size() == 0) begin
          chk("spurious_wb_we", 64'(wb_we), 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("wb_rd", 64'(wb_rd), 64'(e.rd));
          chk("wb_data", 64'(wb_data), 64'(e.data));
        end
      end
    end
  end

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

  initial begin
    model_clear();
    // reset state: stall is a pure function of inputs, nothing pending
    issue_valid = 1'b1; rs1 = 5'd5; rs2 = 5'd6; issue_rd = 5'd7;
    #3;
    chk("reset_stall", 64'(stall), 64'd0);
    chk("reset_alu_ready", 64'(alu_ready), 64'd1);
    chk("reset_wb_we", 64'(wb_we), 64'd0);
    chk("reset_wb_rd", 64'(wb_rd), 64'd0);
    chk("reset_wb_data", 64'(wb_data), 64'd0);
    issue_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;

    // issue rd=5, ALU result follows, dependent reader waits one cycle after write
    cycle(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 6, 5, 0, 1, 5, 32'hAA, 0, 0, 0);
    cycle(1, 6, 5, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 6, 5, 0, 0, 0, 0, 0, 0, 0);
    chk("pending6_after_unstall", 64'(mp[6]), 64'd1);
    cycle(0, 0, 0, 0, 1, 6, 32'h66, 0, 0, 0);
    idle(); idle();

    // load/ALU collision: load first, ALU next, alu_ready low in between
    cycle(0, 0, 0, 0, 1, 4, 32'h22, 1, 3, 32'h11);
    cycle(0, 0, 0, 0, 1, 9, 32'h99, 0, 0, 0);
    idle(); idle();

    // skid held through three loads then drained
    cycle(0, 0, 0, 0, 1, 10, 32'hA0, 1, 1, 32'h01);
    cycle(0, 0, 0, 0, 1, 11, 32'hB0, 1, 2, 32'h02);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 3, 32'h03);
    cycle(0, 0, 0, 0, 0, 0, 0, 1, 4, 32'h04);
    idle(); idle();

    // rd=0 results and rs=0 readers
    cycle(1, 0, 0, 0, 1, 0, 32'hDEAD, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 32'hBEEF, 1, 0, 32'h1);
    cycle(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(); idle();

    // WAW: second issue to rd=7 stalls, one write clears it
    cycle(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 7, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 0);
    cycle(1, 8, 7, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 8, 7, 0, 0, 0, 0, 0, 0, 0);
    chk("pending7_single_clear", 64'(mp[7]), 64'd0);
    idle(); idle();

    // reset while skid FULL and pending = {4,5}
    cycle(1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 1, 12, 32'hC0, 1, 13, 32'hD0);
    do_reset();
    idle(); idle(); idle();

    // random traffic over a small register range to force hazards
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(1, 0), $urandom_range(7, 0), $urandom_range(7, 0), $urandom_range(7, 0),
            $urandom_range(1, 0), $urandom_range(7, 0), $urandom,
            ($urandom_range(2, 0) == 0), $urandom_range(7, 0), $urandom);
    end
    idle(); idle(); idle();
    chk("no_lost_entries", 64'(exp_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/wb_scoreboard.md
WB_SCOREBOARD -- requirements
Module: wb_scoreboard

Interface
REQ-001 SHALL have parameter DATA_W, default 32, the writeback data width.
REQ-002 SHALL have one clock and an asynchronous, active-high reset, with ports named clk and rst.
REQ-003 clk  in  1  all state updates on rising edge.
REQ-004 rst  in  1  async active-high reset.
REQ-005 issue_valid  in  1  decode stage presents an instruction this cycle.
REQ-006 issue_rd  in  5  destination register of the issuing instruction.
REQ-007 rs1, rs2  in  5 each  source registers of the issuing instruction.
REQ-008 stall  out  1  issue blocked this cycle (combinational).
REQ-009 alu_valid  in  1  single-cycle result offered.
REQ-010 alu_rd  in  5  destination of the single-cycle result.
REQ-011 alu_data  in  DATA_W  single-cycle result data.
REQ-012 alu_ready  out  1  single-cycle result accepted when high with alu_valid.
REQ-013 ld_valid  in  1  load response, always accepted (no backpressure).
REQ-014 ld_rd  in  5  load response destination.
REQ-015 ld_data  in  DATA_W  load response data.
REQ-016 wb_we  out  1  register-file write enable (registered).
REQ-017 wb_rd  out  5  register-file write index (registered).
REQ-018 wb_data  out  DATA_W  register-file write data (registered).

Function
REQ-019 SHALL keep a 32-bit pending vector; bit 0 SHALL never be set.
REQ-020 stall SHALL equal issue_valid AND (pending[rs1] OR pending[rs2] OR pending[issue_rd]), with index 0 always treated as not pending.
REQ-021 On an edge with issue_valid=1, stall=0 and issue_rd!=0, pending[issue_rd] SHALL be set.
REQ-022 On an edge with wb_we=1, pending[wb_rd] SHALL clear, coinciding with the register-file write; a reader SHALL unstall in the cycle after that write.
REQ-023 Set and clear of the same index on one edge cannot occur, because of the WAW stall; if both occur anyway, set SHALL win.
REQ-024 SHALL contain a one-entry skid buffer with states EMPTY and FULL; alu_ready SHALL be 1 exactly when the buffer is EMPTY.
REQ-025 Writeback source priority SHALL be: load, then skid, then direct single-cycle result.
REQ-026 ld_valid=1: the load result SHALL be written next cycle; if an accepted single-cycle result collides with it, that result SHALL move to the skid buffer (EMPTY->FULL).
REQ-027 FULL with no load: the skid SHALL drain to writeback (FULL->EMPTY); alu_ready stays 0 during that cycle.
REQ-028 FULL with a load: the skid SHALL hold and stay FULL.
REQ-029 EMPTY, accepted single-cycle result, no load: the result SHALL go directly to writeback, and the buffer SHALL stay EMPTY.
REQ-030 Latency SHALL be one cycle: an entry selected in cycle N SHALL appear on wb_* in cycle N+1.
REQ-031 An entry with rd=0 SHALL be consumed (accepted, skid drained) but SHALL produce wb_we=0.
REQ-032 With no selected entry, wb_we SHALL be 0, and wb_rd and wb_data SHALL hold their previous values.
REQ-033 Outputs SHALL be independent of whether ld_rd is pending; no error checking.

Reset
REQ-034 rst=1 SHALL asynchronously force: pending=0, skid EMPTY, wb_we=0, wb_rd=0, wb_data=0.
REQ-035 While rst=1: alu_ready=1, and stall SHALL follow REQ-020 with pending=0 (a pure function of inputs).
REQ-036 rst asserted mid-operation SHALL discard any skid content and pending bits without emitting a write.

Verification
REQ-037 Issue rd=5, then ALU rd=5 data=0xAA next cycle -> wb_we=1 rd=5 data=0xAA one cycle later; issue with rs1=5 stalls through that cycle and unstalls the cycle after.
REQ-038 ld_valid rd=3 data=0x11 and alu_valid rd=4 data=0x22 in the same cycle -> rd=3 written at N+1, rd=4 at N+2; alu_ready=0 in cycle N+1.
REQ-039 Skid FULL plus ld_valid on three consecutive cycles -> the skid holds, the three loads write back in order, then the skid writes back; no entry lost.
REQ-040 ALU result with rd=0 -> wb_we stays 0; pending unchanged; issue with rs1=0 never stalls.
REQ-041 Issue rd=7 while pending[7]=1 -> stall=1; pending[7] does not double-set.
REQ-042 Assert rst while skid FULL and pending=0x0000_0030 -> immediate pending=0, alu_ready=1, wb_we=0; no writeback after release.
